// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve bundle of the branch predictor, plus its statistics outputs.
// master drives the pipeline side; slave is the predictor.
interface branch_predictor_if #(
  parameter int AddrBit = 10
);
  logic [AddrBit-1:0] if_pc;
  logic               pred_taken;
  logic [AddrBit-1:0] pred_next_pc;
  logic               ex_valid;
  logic               ex_is_ctrl;
  logic               ex_uncond;
  logic [AddrBit-1:0] ex_pc;
  logic               ex_taken;
  logic [AddrBit-1:0] ex_target;
  logic               ex_pred_taken;
  logic [AddrBit-1:0] ex_pred_target;
  logic               mispredict;
  logic [AddrBit-1:0] redirect_pc;
  logic [31:0]        stat_branches;
  logic [31:0]        stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_is_ctrl, ex_uncond, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_next_pc, mispredict, redirect_pc, stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_ctrl, ex_uncond, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_next_pc, mispredict, redirect_pc, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup and EX resolve, table updated on the next edge.
// No backpressure; en=0 freezes table and statistics while the combinational outputs stay live.
module branch_predictor #(
  parameter int         AddrBit  = 10,
  parameter int         IndexBit = 6,
  parameter logic [1:0] AllocCnt = 2'b10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  branch_predictor_if.slave bp
);
  localparam int TagBit  = AddrBit - IndexBit;
  localparam int Entries = 1 << IndexBit;

  logic [Entries-1:0] valid_q;
  logic [TagBit-1:0]  tag_q    [Entries];
  logic [AddrBit-1:0] target_q [Entries];
  logic [1:0]         cnt_q    [Entries];
  logic [31:0]        stat_br_q;
  logic [31:0]        stat_mp_q;

  logic [IndexBit-1:0] if_idx;
  logic [IndexBit-1:0] ex_idx;
  logic [TagBit-1:0]   if_tag;
  logic [TagBit-1:0]   ex_tag;
  logic                if_hit;
  logic                ex_hit;
  logic                ex_ctrl;
  logic                kill_entry;
  logic                upd_entry;
  logic                alloc_entry;
  logic                mispredict;
  logic [1:0]          cnt_next;

  assign if_idx = bp.if_pc[IndexBit-1:0];
  assign if_tag = bp.if_pc[AddrBit-1:IndexBit];
  assign ex_idx = bp.ex_pc[IndexBit-1:0];
  assign ex_tag = bp.ex_pc[AddrBit-1:IndexBit];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign bp.pred_taken   = if_hit && cnt_q[if_idx][1];
  assign bp.pred_next_pc = bp.pred_taken ? target_q[if_idx] : bp.if_pc + AddrBit'(1);

  assign ex_ctrl    = bp.ex_valid && bp.ex_is_ctrl;
  // A non-control instruction can only be "predicted taken" through a stale or aliased entry.
  assign mispredict = bp.ex_valid &&
                      (bp.ex_is_ctrl ? ((bp.ex_taken != bp.ex_pred_taken) ||
                                        (bp.ex_taken && (bp.ex_pred_target != bp.ex_target)))
                                     : bp.ex_pred_taken);

  assign bp.mispredict  = mispredict;
  assign bp.redirect_pc = (bp.ex_is_ctrl && bp.ex_taken) ? bp.ex_target : bp.ex_pc + AddrBit'(1);

  assign kill_entry  = bp.ex_valid && !bp.ex_is_ctrl && bp.ex_pred_taken && ex_hit;
  assign upd_entry   = ex_ctrl && ex_hit;
  assign alloc_entry = ex_ctrl && !ex_hit && bp.ex_taken;

  always_comb begin
    cnt_next = cnt_q[ex_idx];
    if (bp.ex_uncond) begin
      cnt_next = 2'b11;
    end else if (bp.ex_taken) begin
      if (cnt_q[ex_idx] != 2'b11) cnt_next = cnt_q[ex_idx] + 2'd1;
    end else begin
      if (cnt_q[ex_idx] != 2'b00) cnt_next = cnt_q[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (en) begin
      if (ex_ctrl)    stat_br_q <= stat_br_q + 32'd1;
      if (mispredict) stat_mp_q <= stat_mp_q + 32'd1;
      if (clr)              valid_q         <= '0;
      else if (kill_entry)  valid_q[ex_idx] <= 1'b0;
      else if (alloc_entry) valid_q[ex_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (en && !clr) begin
      if (upd_entry) begin
        cnt_q[ex_idx] <= cnt_next;
        if (bp.ex_taken) target_q[ex_idx] <= bp.ex_target;
      end else if (alloc_entry) begin
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bp.ex_target;
        cnt_q[ex_idx]    <= bp.ex_uncond ? 2'b11 : AllocCnt;
      end
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scenario bench for branch_predictor: expectations are queued as stimulus is applied,
// observations are captured away from the clock edge, and each task compares its own queue.
module tb_branch_predictor;
  logic clk;
  logic rst_n;
  logic en;
  logic clr;

  branch_predictor_if #(.AddrBit(10)) bpi ();

  branch_predictor #(.AddrBit(10), .IndexBit(6), .AllocCnt(2'b10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .bp    (bpi)
  );

  typedef enum int {F_PT, F_NPC, F_MP, F_RPC, F_SB, F_SM} fid_e;
  typedef struct {
    fid_e        f;
    logic [31:0] v;
    string       n;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          checks   = 0;
  int          failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(fid_e f);
    case (f)
      F_PT:    return {31'b0, bpi.pred_taken};
      F_NPC:   return {22'b0, bpi.pred_next_pc};
      F_MP:    return {31'b0, bpi.mispredict};
      F_RPC:   return {22'b0, bpi.redirect_pc};
      F_SB:    return bpi.stat_branches;
      default: return bpi.stat_mispredicts;
    endcase
  endfunction

  task automatic want(input fid_e f, input logic [31:0] v, input string n);
    exp_t e;
    e.f = f;
    e.v = v;
    e.n = n;
    exp_q.push_back(e);
  endtask

  // Captures the DUT value for every queued expectation not yet observed.
  task automatic sample();
    #1;
    for (int i = obs_q.size(); i < exp_q.size(); i++) obs_q.push_back(obs(exp_q[i].f));
  endtask

  task automatic ex_set(input logic v, input logic ctrl, input logic unc, input logic [9:0] pc,
                        input logic tk, input logic [9:0] tgt, input logic ptk, input logic [9:0] ptgt);
    bpi.ex_valid       = v;
    bpi.ex_is_ctrl     = ctrl;
    bpi.ex_uncond      = unc;
    bpi.ex_pc          = pc;
    bpi.ex_taken       = tk;
    bpi.ex_target      = tgt;
    bpi.ex_pred_taken  = ptk;
    bpi.ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000);
  endtask

  task automatic lookup(input logic [9:0] pc, input logic pt, input logic [9:0] npc, input string n);
    bpi.if_pc = pc;
    want(F_PT, {31'b0, pt}, {n, "_pt"});
    want(F_NPC, {22'b0, npc}, {n, "_npc"});
    sample();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0;
    ex_idle();
    bpi.if_pc = 10'h004;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lookup(10'h004, 1'b0, 10'h005, "rst_lookup");
    want(F_MP, 0, "rst_mp");
    want(F_SB, 0, "rst_sb");
    want(F_SM, 0, "rst_sm");
    sample();
    lookup(10'h3ff, 1'b0, 10'h000, "rst_wrap");
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_alloc();
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, 10'h010, 1'b1, 10'h020, 1'b0, 10'h011);
    want(F_MP, 1, "alloc_mp");
    want(F_RPC, 10'h020, "alloc_rpc");
    lookup(10'h010, 1'b0, 10'h011, "alloc_pre");
    @(negedge clk);
    ex_idle();
    lookup(10'h010, 1'b1, 10'h020, "alloc_post");
    want(F_SB, 1, "alloc_sb");
    want(F_SM, 1, "alloc_sm");
    sample();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_counter();
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, 10'h010, 1'b0, 10'h020, 1'b1, 10'h020);
    want(F_MP, 1, "nt1_mp");
    want(F_RPC, 10'h011, "nt1_rpc");
    sample();
    @(negedge clk);
    lookup(10'h010, 1'b0, 10'h011, "cnt01");
    ex_set(1'b1, 1'b1, 1'b0, 10'h010, 1'b0, 10'h020, 1'b0, 10'h011);
    want(F_MP, 0, "nt2_mp");
    sample();
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, 10'h010, 1'b1, 10'h020, 1'b0, 10'h011);
    want(F_MP, 1, "tk3_mp");
    want(F_RPC, 10'h020, "tk3_rpc");
    sample();
    @(negedge clk);
    ex_idle();
    lookup(10'h010, 1'b0, 10'h011, "cnt_after_tk");
    want(F_SB, 4, "cnt_sb");
    want(F_SM, 3, "cnt_sm");
    sample();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_alias();
    @(negedge clk);
    lookup(10'h050, 1'b0, 10'h051, "alias_miss");
    ex_set(1'b1, 1'b1, 1'b1, 10'h050, 1'b1, 10'h100, 1'b0, 10'h051);
    want(F_MP, 1, "jmp_mp");
    want(F_RPC, 10'h100, "jmp_rpc");
    sample();
    @(negedge clk);
    ex_idle();
    lookup(10'h010, 1'b0, 10'h011, "alias_evicted");
    lookup(10'h050, 1'b1, 10'h100, "alias_new");
    want(F_SB, 5, "alias_sb");
    want(F_SM, 4, "alias_sm");
    sample();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_noncontrol();
    @(negedge clk);
    ex_set(1'b1, 1'b0, 1'b0, 10'h050, 1'b0, 10'h000, 1'b1, 10'h100);
    want(F_MP, 1, "nc_mp");
    want(F_RPC, 10'h051, "nc_rpc");
    sample();
    @(negedge clk);
    ex_idle();
    lookup(10'h050, 1'b0, 10'h051, "nc_killed");
    want(F_SB, 5, "nc_sb");
    want(F_SM, 5, "nc_sm");
    sample();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_en_clr_reset();
    @(negedge clk);
    en = 1'b0;
    ex_set(1'b1, 1'b1, 1'b0, 10'h010, 1'b1, 10'h030, 1'b0, 10'h011);
    want(F_MP, 1, "en0_mp");
    want(F_RPC, 10'h030, "en0_rpc");
    sample();
    @(negedge clk);
    en = 1'b1;
    ex_idle();
    lookup(10'h010, 1'b0, 10'h011, "en0_hold");
    want(F_SB, 5, "en0_sb");
    want(F_SM, 5, "en0_sm");
    sample();
    ex_set(1'b1, 1'b1, 1'b0, 10'h020, 1'b1, 10'h040, 1'b0, 10'h021);
    @(negedge clk);
    ex_idle();
    lookup(10'h020, 1'b1, 10'h040, "pre_clr");
    clr = 1'b1;
    ex_set(1'b1, 1'b1, 1'b0, 10'h030, 1'b1, 10'h050, 1'b0, 10'h031);
    @(negedge clk);
    clr = 1'b0;
    ex_idle();
    lookup(10'h020, 1'b0, 10'h021, "clr_old");
    lookup(10'h030, 1'b0, 10'h031, "clr_new");
    want(F_SB, 7, "clr_sb");
    want(F_SM, 7, "clr_sm");
    sample();
    rst_n = 1'b0;
    want(F_SB, 0, "arst_sb");
    want(F_SM, 0, "arst_sm");
    sample();
    @(negedge clk);
    rst_n = 1'b1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, 10'h008, 1'b1, 10'h0a0, 1'b0, 10'h009);
    sample();
    @(negedge clk);
    lookup(10'h008, 1'b1, 10'h0a0, "sat_alloc");
    ex_set(1'b1, 1'b1, 1'b0, 10'h008, 1'b1, 10'h0a0, 1'b1, 10'h0a0);
    want(F_MP, 0, "sat_ok_mp");
    sample();
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, 10'h008, 1'b1, 10'h0a0, 1'b1, 10'h0a1);
    want(F_MP, 1, "sat_badtgt_mp");
    want(F_RPC, 10'h0a0, "sat_badtgt_rpc");
    sample();
    @(negedge clk);
    ex_set(1'b1, 1'b1, 1'b0, 10'h008, 1'b0, 10'h0a0, 1'b1, 10'h0a0);
    want(F_MP, 1, "sat_nt_mp");
    want(F_RPC, 10'h009, "sat_nt_rpc");
    sample();
    @(negedge clk);
    ex_idle();
    lookup(10'h008, 1'b1, 10'h0a0, "sat_hold");
    want(F_SB, 4, "sat_sb");
    want(F_SM, 3, "sat_sm");
    sample();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp_t e; logic [31:0] o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin failures++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_noncontrol();
    test_en_clr_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage pipeline.
- Predicts the next PC in IF, so taken branches and jumps that hit in the table no longer flush IF/ID and ID/EX.
- Resolves the prediction in EX, producing the mispredict flag and the redirect PC.
- Keeps branch and mispredict statistics counters for the debug display.

Parameters:
AddrBit, 10, width of word-granular instruction address (matches instruction-memory address width)
IndexBit, 6, log2 of table entries (default 64); must satisfy 1 <= IndexBit < AddrBit
AllocCnt, 2'b10, counter value written when a taken branch allocates a new entry

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; when low, no state changes
clr  in  1  synchronous invalidate of all entries
if_pc  in  AddrBit  PC currently being fetched
pred_taken  out  1  IF prediction: taken
pred_next_pc  out  AddrBit  IF next PC: target if taken, else if_pc+1
ex_valid  in  1  EX holds a real instruction (not a bubble)
ex_is_ctrl  in  1  EX instruction is a branch or jump
ex_uncond  in  1  EX instruction is an unconditional jump (valid with ex_is_ctrl)
ex_pc  in  AddrBit  PC of the EX instruction
ex_taken  in  1  resolved direction
ex_target  in  AddrBit  resolved target
ex_pred_taken  in  1  prediction made for this instruction, carried through the pipeline
ex_pred_target  in  AddrBit  predicted next PC, carried through the pipeline
mispredict  out  1  flush IF/ID and ID/EX, load redirect_pc
redirect_pc  out  AddrBit  corrected next PC
stat_branches  out  32  resolved control instructions
stat_mispredicts  out  32  mispredicts

Behaviour:
- Index = pc[IndexBit-1:0]; tag = pc[AddrBit-1:IndexBit].
- Each entry holds: valid, tag, target (AddrBit bits), cnt (2 bits).
- Lookup (combinational from registered table state):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[1].
  - pred_next_pc = pred_taken ? target : if_pc+1, with modulo 2^AddrBit wrap.
- Resolution (combinational):
  - Mispredict on a control instruction (ex_valid && ex_is_ctrl): taken != ex_pred_taken, OR taken and ex_pred_target != ex_target.
  - Mispredict on a non-control instruction (ex_valid && !ex_is_ctrl) that was predicted taken.
  - mispredict = 0 whenever ex_valid = 0.
  - redirect_pc = (ex_is_ctrl && ex_taken) ? ex_target : ex_pc+1 (wraps).
- Update on a rising edge with en=1, priority order:
  1. clr: all valid bits cleared; the update that cycle is discarded.
  2. Non-control instruction with ex_pred_taken=1: invalidate the entry at ex_pc's index if its tag matches.
  3. Control instruction that hits: if ex_uncond, cnt := 2'b11; else saturating increment if taken, decrement if not (11 stays 11, 00 stays 00). Target := ex_target when taken.
  4. Control instruction that misses and is taken: allocate (overwrite any occupant); valid=1, tag, target. cnt := 2'b11 if ex_uncond, else AllocCnt.
  5. Control instruction that misses and is not taken: no allocation.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents; the update is visible from the next cycle.
- Statistics:
  - stat_branches increments on an enabled edge when ex_valid && ex_is_ctrl.
  - stat_mispredicts increments on an enabled edge when mispredict.
  - Both wrap modulo 2^32; both still count on a clr cycle.
- en=0: table and stats hold; combinational outputs remain live.
- Reset (asynchronous, rst_n low):
  - All valid bits 0, stat counters 0.
  - With the table empty and ex_valid=0: pred_taken=0, pred_next_pc=if_pc+1, mispredict=0.
  - Reset asserted mid-update wins; the update is lost.

Test Plan:
1. After reset, if_pc=10'h004 -> pred_taken=0, pred_next_pc=10'h005; stats 0.
2. Resolve taken branch at ex_pc=10'h010 to target 10'h020 with ex_pred_taken=0 -> mispredict=1, redirect_pc=10'h020. Next cycle if_pc=10'h010 -> pred_taken=1, pred_next_pc=10'h020. stat_branches=1, stat_mispredicts=1.
3. Same branch resolved not-taken twice -> cnt 10->01->00, pred_taken=0. Third resolve taken -> cnt 01, still predicts not-taken.
4. Alias: entry at 10'h010; lookup 10'h050 (same index, different tag) -> miss, pred_next_pc=10'h051. Jump at 10'h050 to 10'h100 replaces the entry; 10'h010 now misses.
5. Non-control instruction at 10'h050 arrives with ex_pred_taken=1 -> mispredict=1, redirect_pc=10'h051, entry invalidated.
6. en=0 during a taken resolve -> no table or stat change. clr with a simultaneous update -> all entries miss next cycle; stat_branches still increments. Toggle rst_n mid-cycle -> stats 0 immediately.
